// File: rtl/onehot_event_encoder_if.sv
// Valid/ready channel carrying 2-bit event codes from the encoder to a consumer.
interface onehot_event_encoder_if;
    logic [1:0] code;
    logic       valid;
    logic       ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/onehot_event_encoder.sv
// Rising-edge request encoder: serialises edges on four lines by fixed priority
// (bit 3 highest) and queues their 2-bit codes in a small FIFO.
module onehot_event_encoder #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   req,
    onehot_event_encoder_if.master       evt,
    output logic [CW-1:0]                count,
    output logic                         overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    req_q;
    logic [3:0]    pending;
    logic [3:0]    rise;
    logic [3:0]    grant;
    logic [1:0]    enc;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          has_event;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          drop;

    function automatic logic [3:0] prio_grant(input logic [3:0] p);
        logic [3:0] g;
        g = 4'b0000;
        if      (p[3]) g = 4'b1000;
        else if (p[2]) g = 4'b0100;
        else if (p[1]) g = 4'b0010;
        else if (p[0]) g = 4'b0001;
        return g;
    endfunction

    function automatic logic [1:0] prio_index(input logic [3:0] p);
        logic [1:0] idx;
        idx = 2'b00;
        if      (p[3]) idx = 2'b11;
        else if (p[2]) idx = 2'b10;
        else if (p[1]) idx = 2'b01;
        return idx;
    endfunction

    always_comb begin
        rise      = req & ~req_q;
        grant     = prio_grant(pending);
        enc       = prio_index(pending);
        has_event = |pending;
        not_empty = (count != '0);
        pop       = not_empty && evt.ready;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push      = has_event && ((count < CW'(DEPTH)) || pop);
        drop      = has_event && !push;
    end

    assign evt.valid = not_empty;
    assign evt.code  = not_empty ? mem[rd_ptr] : 2'b00;

    // Edge detect and pending set/clear; rise wins over a same-cycle grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 4'b0000;
            pending  <= 4'b0000;
            overflow <= 1'b0;
        end else begin
            req_q   <= req;
            pending <= (pending & ~grant) | rise;
            if (drop) overflow <= 1'b1;
        end
    end

    // FIFO control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage holds data only and is not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc;
    end
endmodule

// File: tb/tb_onehot_event_encoder.sv
// Directed bench for onehot_event_encoder: priority, full/overflow, wrap and async reset.
module tb_onehot_event_encoder;
    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [2:0] count;
    logic       overflow;
    int         n_checks;
    int         n_errors;

    onehot_event_encoder_if evt_if ();

    onehot_event_encoder #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .evt      (evt_if),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] r);
        req = r;
        tick();
        req = 4'b0000;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_q [$];
    logic [1:0] seq [10];
    int         ev;
    int         popped;

    initial begin
        n_checks = 0;
        n_errors = 0;
        req = 4'b0000;
        evt_if.ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(evt_if.valid), 0);
        check("rst_code", 32'(evt_if.code), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;

        // Single event
        req = 4'b0100;
        tick();
        check("single_lat1_valid", 32'(evt_if.valid), 0);
        req = 4'b0000;
        tick();
        check("single_valid", 32'(evt_if.valid), 1);
        check("single_code", 32'(evt_if.code), 2);
        check("single_count", 32'(count), 1);
        evt_if.ready = 1'b1;
        tick();
        check("single_pop_valid", 32'(evt_if.valid), 0);
        check("single_pop_count", 32'(count), 0);

        // Priority serialisation
        req = 4'b1011;
        tick();
        tick();
        check("prio_v0", 32'(evt_if.valid), 1);
        check("prio_c0", 32'(evt_if.code), 3);
        tick();
        check("prio_v1", 32'(evt_if.valid), 1);
        check("prio_c1", 32'(evt_if.code), 1);
        tick();
        check("prio_v2", 32'(evt_if.valid), 1);
        check("prio_c2", 32'(evt_if.code), 0);
        tick();
        check("prio_empty", 32'(evt_if.valid), 0);
        tick();
        tick();
        check("prio_held_valid", 32'(evt_if.valid), 0);
        check("prio_held_count", 32'(count), 0);
        req = 4'b0000;
        evt_if.ready = 1'b0;
        tick();

        // Full / overflow
        for (int i = 0; i < 4; i++) pulse(4'b0010);
        check("full_count", 32'(count), 4);
        check("full_ovf0", 32'(overflow), 0);
        pulse(4'b0010);
        check("ovf_count", 32'(count), 4);
        check("ovf_set", 32'(overflow), 1);
        evt_if.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(evt_if.valid), 1);
            check("drain_code", 32'(evt_if.code), 1);
            tick();
        end
        check("drain_empty", 32'(evt_if.valid), 0);
        check("drain_count", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        evt_if.ready = 1'b0;

        // Full with simultaneous pop
        do_reset();
        check("reset_clears_ovf", 32'(overflow), 0);
        pulse(4'b0001);
        pulse(4'b0010);
        pulse(4'b0100);
        pulse(4'b0001);
        check("fp_full", 32'(count), 4);
        req = 4'b1000;
        tick();
        evt_if.ready = 1'b1;
        req = 4'b0000;
        tick();
        check("fp_count", 32'(count), 4);
        check("fp_ovf", 32'(overflow), 0);
        check("fp_h1", 32'(evt_if.code), 1);
        tick();
        check("fp_h2", 32'(evt_if.code), 2);
        tick();
        check("fp_h3", 32'(evt_if.code), 0);
        tick();
        check("fp_last", 32'(evt_if.code), 3);
        check("fp_last_valid", 32'(evt_if.valid), 1);
        tick();
        check("fp_empty", 32'(evt_if.valid), 0);
        evt_if.ready = 1'b0;

        // Wrap-around with ready toggling
        seq = '{2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2};
        ev = 0;
        popped = 0;
        for (int c = 0; c < 40; c++) begin
            evt_if.ready = c[0];
            if (evt_if.valid && evt_if.ready) begin
                if (exp_q.size() == 0) check("wrap_unexpected", 32'(evt_if.code), 32'hff);
                else check("wrap_code", 32'(evt_if.code), 32'(exp_q.pop_front()));
                popped++;
            end
            if (c[0] == 1'b0 && ev < 10) begin
                req = 4'b0001 << seq[ev];
                exp_q.push_back(seq[ev]);
                ev++;
            end else begin
                req = 4'b0000;
            end
            tick();
            check("wrap_count_le4", 32'(count <= 3'd4), 1);
        end
        check("wrap_popped", popped, 10);
        check("wrap_ovf", 32'(overflow), 0);
        evt_if.ready = 1'b0;

        // Async reset mid-stream
        pulse(4'b1000);
        pulse(4'b0100);
        pulse(4'b0010);
        check("ar_count3", 32'(count), 3);
        check("ar_code3", 32'(evt_if.code), 3);
        #3;
        rst = 1'b1;
        req = 4'b0001;
        #1;
        check("ar_valid", 32'(evt_if.valid), 0);
        check("ar_count", 32'(count), 0);
        check("ar_code", 32'(evt_if.code), 0);
        tick();
        #3;
        rst = 1'b0;
        tick();
        check("ar_lat1", 32'(evt_if.valid), 0);
        tick();
        check("ar_valid2", 32'(evt_if.valid), 1);
        check("ar_code2", 32'(evt_if.code), 0);
        check("ar_count2", 32'(count), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/onehot_event_encoder.md
Name: onehot_event_encoder

Overview:
- Inverse of the 2-to-4 one-hot decoder: turns rising edges on four request lines into 2-bit binary codes.
- Serialises simultaneous events by fixed priority and buffers them in a small FIFO.
- Presents codes to a downstream consumer over a valid/ready handshake.
- Sits between switch/key or one-hot status inputs and any logic that consumes compact event codes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit i rising edge = event with code i.
- code  output  2  FIFO head code; 2'b00 when empty.
- valid  output  1  FIFO non-empty.
- ready  input  1  consumer accepts head when valid && ready at a clk edge.
- count  output  CW  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst=1): req_q=0, pending=0, FIFO pointers=0, count=0, overflow=0. Outputs read code=0, valid=0, count=0, overflow=0 immediately and while rst is held.
- Edge detect: rise = req & ~req_q (combinational); req_q <= req every clk.
  - A line already high when rst deasserts produces an event on the first clk after release.
- Pending register, 4 bits: pending <= (pending & ~grant) | rise.
  - grant = one-hot of the highest set bit of pending; bit3 has highest priority.
  - A rise on a bit that is already pending merges: it is counted once.
- Encode: enc = index of the grant bit, i.e. 3->2'b11, 2->2'b10, 1->2'b01, 0->2'b00. Exactly one event is encoded per cycle when pending != 0.
- Push: when pending != 0, write enc at the write pointer.
  - Allowed if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
  - Otherwise the event is dropped: its pending bit is still cleared and overflow <= 1.
  - overflow stays at 1 until rst.
- Pop: occurs when valid && ready. It advances the read pointer.
  - ready while valid=0 has no effect.
  - Pointers wrap modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop in the same cycle, or on neither.
- Latency: a req bit rising before clk edge k sets pending at edge k and pushes at edge k+1. valid is high after edge k+1, giving 2 cycles from input to output with an empty FIFO.
- Throughput: one push and one pop per cycle. N simultaneous rises drain from pending over N consecutive cycles in descending code order.
- code/valid/count/overflow are registered or derived only from registered state. No combinational path from req or ready to any output.
- Falling edges and held-high levels generate no events. A line must go low and then high again to produce a new event.
- A rise on a line that is being granted in the same cycle re-sets that pending bit. The rise term wins, so one more event is queued.
- Reset mid-operation discards pending and buffered events with no partial output. The first clk after release behaves as after power-up.

Test Plan:
- Single event: after reset, req=4'b0100 for 1 cycle with ready=0. Required: valid=1 two edges later, code=2'b10, count=1. Then ready=1 for 1 cycle gives valid=0, count=0.
- Priority serialisation: req 4'b0000->4'b1011 in one cycle with ready=1. Required: codes 2'b11, 2'b01, 2'b00 appear on consecutive cycles, each with valid=1; no further events while req stays 4'b1011.
- Full/overflow with DEPTH=4 and ready=0: five separate rising edges on req[1]. Required: count saturates at 4, all entries are 2'b01, and overflow=1 after the 5th push attempt. Draining yields exactly 4 codes, and overflow stays 1.
- Full with simultaneous pop: FIFO full, ready=1, new rise on req[3] in the same cycle as a pop. Required: no drop, overflow stays 0, count stays 4, and 2'b11 is the last entry out.
- Wrap-around: 10 events pass through DEPTH=4 with ready toggling 1/0 each cycle. Required: codes exit in push order, count never exceeds 4, no overflow.
- Async reset mid-stream: assert rst between clk edges with count=3. Required: valid, count and code go to 0 before the next edge. After release with req=4'b0001 already held high, code 2'b00 appears 2 edges later.
